// File: rtl/ed25519_io_ctrl.sv
// Stream sequencer for the ed25519 scalar-multiplication core: collects 12 input
// words into scalar/Px/Py, starts the core, then streams Qx/Qy back as 8 words.
module ed25519_io_ctrl #(
  parameter int DATA_W      = 64,
  parameter int PATN_W      = 256,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [PATN_W-1:0] o_scalar,
  output logic [PATN_W-1:0] o_px,
  output logic [PATN_W-1:0] o_py,
  output logic              o_start,
  input  logic              i_done,
  input  logic [PATN_W-1:0] i_qx,
  input  logic [PATN_W-1:0] i_qy,
  output logic              o_busy,
  output logic              o_err
);
  localparam int WPE       = PATN_W / DATA_W;
  localparam int IN_WORDS  = 3 * WPE;
  localparam int OUT_WORDS = 2 * WPE;

  typedef enum logic [2:0] {S_LOAD, S_START, S_WAIT, S_SEND, S_ERR} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [31:0]         r_wdog;
  logic [PATN_W-1:0]   r_scalar, r_px, r_py;
  logic [2*PATN_W-1:0] r_shift;
  logic                r_in_ready, r_out_valid, r_start, r_busy, r_err;
  logic [3:0]          w_elem, w_slot;

  // Word counter splits into (which element, which 64-bit slot within it).
  assign w_elem = r_cnt / 4'(WPE);
  assign w_slot = r_cnt % 4'(WPE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_wdog      <= '0;
      r_scalar    <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_shift     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (i_in_valid && r_in_ready) begin
            for (int k = 0; k < WPE; k++) begin
              if (w_slot == 4'(k)) begin
                case (w_elem)
                  4'd0:    r_scalar[(WPE-1-k)*DATA_W +: DATA_W] <= i_in_data;
                  4'd1:    r_px[(WPE-1-k)*DATA_W +: DATA_W]     <= i_in_data;
                  default: r_py[(WPE-1-k)*DATA_W +: DATA_W]     <= i_in_data;
                endcase
              end
            end
            if (r_cnt == 4'(IN_WORDS-1)) begin
              r_cnt      <= '0;
              r_state    <= S_START;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_start    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_done) begin
            r_shift     <= {i_qx, i_qy};
            r_out_valid <= 1'b1;
            r_wdog      <= '0;
            r_state     <= S_SEND;
          end else if (TIMEOUT_CYC > 0 && r_wdog == 32'(TIMEOUT_CYC-1)) begin
            r_err   <= 1'b1;
            r_wdog  <= '0;
            r_state <= S_ERR;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        S_SEND: begin
          if (r_out_valid && i_out_ready) begin
            r_shift <= r_shift << DATA_W;
            if (r_cnt == 4'(OUT_WORDS-1)) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_ERR: r_state <= S_ERR;
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_shift[2*PATN_W-1 -: DATA_W];
  assign o_scalar    = r_scalar;
  assign o_px        = r_px;
  assign o_py        = r_py;
  assign o_start     = r_start;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// Directed self-checking bench for ed25519_io_ctrl with a behavioural core model.
module tb_ed25519_io_ctrl;
  localparam logic [255:0] BX = 256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
  localparam logic [255:0] BY = 256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam logic [255:0] QA = {32{8'hAA}};
  localparam logic [255:0] Q5 = {32{8'h55}};

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [63:0]  i_in_data = '0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [63:0]  o_out_data;
  logic [255:0] o_scalar, o_px, o_py;
  logic         o_start;
  logic         i_done = 1'b0;
  logic [255:0] i_qx = '0, i_qy = '0;
  logic         o_busy, o_err;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cnt = 0, in_xfer = 0;
  int last_in_cyc, first_out_cyc;

  ed25519_io_ctrl #(.DATA_W(64), .PATN_W(256), .TIMEOUT_CYC(100)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_scalar(o_scalar), .o_px(o_px), .o_py(o_py), .o_start(o_start),
    .i_done(i_done), .i_qx(i_qx), .i_qy(i_qy), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_start) start_cnt <= start_cnt + 1;
    if (i_in_valid && o_in_ready) in_xfer <= in_xfer + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_job(input logic [255:0] s, input logic [255:0] px,
                          input logic [255:0] py, input bit stall);
    logic [767:0] all;
    int idx, budget;
    bit v, r;
    all = {s, px, py};
    idx = 0;
    budget = 0;
    while (idx < 12 && budget < 1000) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_valid = v;
      i_in_data  = all[767-64*idx -: 64];
      r = o_in_ready;
      @(posedge i_clk); #1;
      budget++;
      if (v && r) begin
        idx++;
        last_in_cyc = cyc;
      end
    end
    i_in_valid = 1'b0;
    chk("in_words", 256'(idx), 256'd12);
  endtask

  task automatic core_run(input int lat, input logic [255:0] qx, input logic [255:0] qy,
                          input bit hold);
    int budget;
    budget = 0;
    while (!o_start && budget < 1000) begin
      @(posedge i_clk); #1;
      budget++;
    end
    chk("start_seen", 256'(o_start), 256'd1);
    @(posedge i_clk); #1;
    i_done = 1'b0;
    i_qx = qx;
    i_qy = qy;
    repeat (lat) @(posedge i_clk);
    #1 i_done = 1'b1;
    @(posedge i_clk); #1;
    if (hold) begin
      repeat (10) @(posedge i_clk);
      #1;
    end
    i_done = 1'b0;
  endtask

  task automatic recv_job(input logic [255:0] qx, input logic [255:0] qy,
                          input int nwords, input bit stall);
    logic [511:0] all;
    logic [63:0]  dat;
    int cnt, budget;
    bit v, r;
    all = {qx, qy};
    cnt = 0;
    budget = 0;
    first_out_cyc = -1;
    while (cnt < nwords && budget < 1000) begin
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_out_ready = r;
      v = o_out_valid;
      dat = o_out_data;
      if (v && first_out_cyc < 0) first_out_cyc = cyc;
      @(posedge i_clk); #1;
      budget++;
      if (v && r) begin
        chk($sformatf("out_word%0d", cnt), 256'(dat), 256'(all[511-64*cnt -: 64]));
        cnt++;
      end else if (v) begin
        chk("hold_valid", 256'(o_out_valid), 256'd1);
        chk("hold_data", 256'(o_out_data), 256'(dat));
      end
    end
    i_out_ready = 1'b0;
    chk("out_words", 256'(cnt), 256'(nwords));
    if (nwords == 8) begin
      chk("end_busy", 256'(o_busy), 256'd0);
      chk("end_valid", 256'(o_out_valid), 256'd0);
      chk("end_ready", 256'(o_in_ready), 256'd1);
    end
  endtask

  task automatic run_job(input logic [255:0] s, input logic [255:0] px, input logic [255:0] py,
                         input logic [255:0] qx, input logic [255:0] qy, input int lat,
                         input bit stall, input bit early);
    int sc;
    sc = start_cnt;
    if (early) begin
      i_done = 1'b1;
      i_qx = ~qx;
      i_qy = ~qy;
    end
    fork
      send_job(s, px, py, stall);
      core_run(lat, qx, qy, early);
      recv_job(qx, qy, 8, stall);
    join
    chk("scalar", o_scalar, s);
    chk("px", o_px, px);
    chk("py", o_py, py);
    chk("latency", 256'(first_out_cyc - last_in_cyc), 256'(lat + 2));
    chk("start_pulses", 256'(start_cnt - sc), 256'd1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int x0, budget;
    do_reset();
    chk("rst_in_ready", 256'(o_in_ready), 256'd1);
    chk("rst_out_valid", 256'(o_out_valid), 256'd0);
    chk("rst_start", 256'(o_start), 256'd0);
    chk("rst_busy", 256'(o_busy), 256'd0);
    chk("rst_err", 256'(o_err), 256'd0);
    chk("rst_scalar", o_scalar, 256'd0);

    // Directed base-point job, core answers five cycles after start.
    run_job(256'd1, BX, BY, QA, Q5, 5, 1'b0, 1'b0);

    // Back-to-back jobs with random stalls on both sides.
    run_job(256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
            BY, BX, 256'hDEADBEEF_00000001_11111111_22222222_33333333_44444444_55555555_66666666,
            256'hCAFEF00D_77777777_88888888_99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
            3, 1'b1, 1'b0);
    run_job(~BX, ~BY, 256'h1, Q5, QA, 0, 1'b1, 1'b0);
    run_job(256'h8000000000000000_0000000000000000_0000000000000000_0000000000000001,
            256'hFFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000,
            256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF,
            BX, BY, 7, 1'b1, 1'b0);

    // Done held through LOAD/START and into SEND must only count once, in WAIT.
    run_job(256'd42, BY, BX, BY, BX, 4, 1'b0, 1'b1);

    // Reset in the middle of SEND after three output words.
    fork
      send_job(256'd7, BX, BY, 1'b0);
      core_run(2, QA, Q5, 1'b0);
      recv_job(QA, Q5, 3, 1'b0);
    join
    do_reset();
    chk("mid_valid", 256'(o_out_valid), 256'd0);
    chk("mid_data", 256'(o_out_data), 256'd0);
    chk("mid_scalar", o_scalar, 256'd0);
    chk("mid_px", o_px, 256'd0);
    chk("mid_py", o_py, 256'd0);
    chk("mid_busy", 256'(o_busy), 256'd0);
    chk("mid_ready", 256'(o_in_ready), 256'd1);
    run_job(256'd9, BY, BX, Q5, QA, 5, 1'b0, 1'b0);

    // Next job's first word waits on the bus for the whole SEND phase.
    x0 = 0;
    fork
      run_job(256'd3, BX, BY, QA, Q5, 2, 1'b0, 1'b0);
      begin
        budget = 0;
        while (!o_out_valid && budget < 1000) begin
          @(posedge i_clk); #1;
          budget++;
        end
        i_in_data  = 64'hB2B0_0000_0000_0001;
        i_in_valid = 1'b1;
        x0 = in_xfer;
      end
    join
    chk("b2b_no_accept", 256'(in_xfer), 256'(x0));
    run_job(256'hB2B0_0000_0000_0001_0000_0000_0000_0002_0000_0000_0000_0003_0000_0000_0000_0004,
            BX, BY, BY, BX, 1, 1'b0, 1'b0);

    // Watchdog: core never answers, error after 100 WAIT cycles.
    send_job(256'd5, BX, BY, 1'b0);
    chk("wd_start", 256'(o_start), 256'd1);
    @(posedge i_clk);
    repeat (99) @(posedge i_clk);
    #1 chk("wd_err_early", 256'(o_err), 256'd0);
    @(posedge i_clk); #1;
    chk("wd_err", 256'(o_err), 256'd1);
    chk("wd_ready", 256'(o_in_ready), 256'd0);
    i_in_valid = 1'b1;
    repeat (20) @(posedge i_clk);
    #1;
    chk("wd_err_sticky", 256'(o_err), 256'd1);
    chk("wd_ready_sticky", 256'(o_in_ready), 256'd0);
    chk("wd_valid", 256'(o_out_valid), 256'd0);
    i_in_valid = 1'b0;
    do_reset();
    chk("wd_clr_err", 256'(o_err), 256'd0);
    chk("wd_clr_ready", 256'(o_in_ready), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ed25519_io_ctrl.md
Name: ed25519_io_ctrl

Overview:
- Sequencer between the 64-bit valid/ready stream port of the ed25519 top and the 256-bit scalar-multiplication core.
- Deserializes 12 input words into scalar, Px and Py, then pulses the core start and waits for core done.
- Captures Qx and Qy, then serializes them as 8 output words with backpressure.
- One job at a time, with an optional watchdog timeout.

Parameters:
- DATA_W, 64, stream word width.
- PATN_W, 256, field-element width; IN_WORDS = 3*PATN_W/DATA_W = 12, OUT_WORDS = 2*PATN_W/DATA_W = 8.
- TIMEOUT_CYC, 0, maximum cycles spent in WAIT before error; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  controller accepts an input word.
- i_in_data  in  DATA_W  input word.
- o_out_valid  out  1  output word valid.
- i_out_ready  in  1  downstream accepts the output word.
- o_out_data  out  DATA_W  output word.
- o_scalar  out  PATN_W  scalar register to the core.
- o_px  out  PATN_W  point x register to the core.
- o_py  out  PATN_W  point y register to the core.
- o_start  out  1  one-cycle core start pulse.
- i_done  in  1  core result valid (pulse or level).
- i_qx  in  PATN_W  result x, sampled when i_done=1 in WAIT.
- i_qy  in  PATN_W  result y, sampled when i_done=1 in WAIT.
- o_busy  out  1  high in every state except LOAD.
- o_err  out  1  sticky watchdog error.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - State goes to LOAD; word counter is 0; watchdog counter is 0.
  - o_scalar/o_px/o_py/output shift register are 0.
  - o_in_ready=1 in the first cycle after reset; o_out_valid=0, o_start=0, o_busy=0, o_err=0.
  - Reset mid-job aborts the job with no residual output.
- Handshakes:
  - Transfer occurs when valid and ready are both high at a rising edge.
  - o_out_data and o_out_valid are held stable while o_out_valid=1 and i_out_ready=0.
  - o_in_ready and o_out_valid are registered outputs; neither depends combinationally on i_in_valid or i_out_ready.
- LOAD:
  - o_in_ready=1.
  - Words arrive MSB-first: words 0..3 are scalar[255:192]..scalar[63:0], words 4..7 are Px, words 8..11 are Py, each in the same order.
  - Each transfer writes the addressed 64-bit slice and increments the counter.
  - On word 11: counter resets to 0, go to START, and o_in_ready=0 from the next cycle.
  - i_done is ignored in LOAD.
- START:
  - o_start=1 for exactly one cycle, then go to WAIT.
  - Last-input-transfer edge N -> o_start high during cycle N+1.
- WAIT:
  - The watchdog counter increments each cycle.
  - If i_done=1: latch {i_qx,i_qy} into the 512-bit output shift register and go to SEND.
  - i_done high in the same cycle as START is not sampled; sampling begins in the first WAIT cycle.
  - Done sampled at edge M -> o_out_valid=1 during cycle M+1 with o_out_data=Qx[255:192].
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC with no done: go to ERR.
- SEND:
  - o_out_valid=1.
  - Output order: Qx[255:192]..Qx[63:0], then Qy[255:192]..Qy[63:0].
  - Each output transfer shifts the register left by DATA_W and increments the counter.
  - After the 8th transfer: o_out_valid=0 and return to LOAD, so o_in_ready=1 in the next cycle.
  - i_done is ignored in SEND.
- ERR:
  - o_err=1, o_in_ready=0, o_out_valid=0.
  - Only reset exits ERR.
- Counters are 4 bits for words and 32 bits for the watchdog; neither wraps, because the FSM resets them on every state exit.
- Stalls (i_in_valid=0 or i_out_ready=0) cost cycles only; they never corrupt or reorder data.

Test Plan:
- Directed job: scalar=1, Px=0x2169..(base x), Py=0x6666..58; model core returns Qx=0xAA..AA, Qy=0x55..55 five cycles after start -> exactly one o_start pulse, 8 output words 0xAAAA_AAAA_AAAA_AAAA x4 then 0x5555_5555_5555_5555 x4, o_busy falls after the last word.
- Random stalls: i_in_valid and i_out_ready toggled by $random%2 for 3 back-to-back jobs -> o_scalar/o_px/o_py match inputs bit-exact; output stable under stall; per-job latency from last input to first output = core latency + 2.
- Early/late done: i_done held high during LOAD and asserted concurrently with o_start -> ignored; only a done in WAIT triggers SEND; no duplicate outputs.
- Watchdog: TIMEOUT_CYC=100, core never responds -> o_err=1 at WAIT cycle 100, o_in_ready stays 0; i_rst_n=0 for 1 cycle clears o_err and restores o_in_ready=1.
- Reset mid-SEND after 3 output words -> next cycle o_out_valid=0, all registers are 0, and the following full job produces correct 8 words.
- Back-to-back boundary: new i_in_valid held high during SEND -> no input accepted until the cycle after the 8th output transfer; first accepted word then lands in scalar[255:192].
